// File: rtl/tpu_requant_packer_if.sv
// ----------------------------------------------------------------------------
// tpu_requant_packer_if
// Bundles the configuration, job-control, C-buffer read and packed-output
// signals of the requantization packer.
//   slave  : the packer side (consumes cfg/job/read data/out_ready,
//            produces busy/done/read strobe/output word)
//   master : the surrounding system side (mirror image of slave)
// Signal summary:
//   cfg_we, cfg_sel[2:0], cfg_data[31:0]   config register write port
//   start, base_addr, num_rows             job launch (sampled on start)
//   busy, done                             job status
//   c_rd_en, c_rd_addr, c_rd_data[127:0]   C buffer read (data one cycle later)
//   out_valid, out_ready, out_data[31:0]   packed int8x4 result stream
// ----------------------------------------------------------------------------
interface tpu_requant_packer_if #(
   parameter int ADDR_W = 8,
   parameter int ROWS_W = 8
);
   logic              cfg_we;
   logic [2:0]        cfg_sel;
   logic [31:0]       cfg_data;
   logic              start;
   logic [ADDR_W-1:0] base_addr;
   logic [ROWS_W-1:0] num_rows;
   logic              busy;
   logic              done;
   logic              c_rd_en;
   logic [ADDR_W-1:0] c_rd_addr;
   logic [127:0]      c_rd_data;
   logic              out_valid;
   logic              out_ready;
   logic [31:0]       out_data;

   modport slave (
      input  cfg_we, cfg_sel, cfg_data, start, base_addr, num_rows,
      input  c_rd_data, out_ready,
      output busy, done, c_rd_en, c_rd_addr, out_valid, out_data
   );

   modport master (
      output cfg_we, cfg_sel, cfg_data, start, base_addr, num_rows,
      output c_rd_data, out_ready,
      input  busy, done, c_rd_en, c_rd_addr, out_valid, out_data
   );
endinterface

// File: rtl/tpu_requant_packer.sv
// ----------------------------------------------------------------------------
// tpu_requant_packer
// Output stage behind the TPU accumulator (C) buffer. Streams rows of four
// int32 accumulators, applies per-layer requantization (saturating rounding
// doubling high multiply, rounding right shift, output offset, activation
// clamp) and packs the four int8 results into one 32-bit word.
// Ports:
//   clk    clock
//   rst_n  asynchronous active-low reset
//   bus    tpu_requant_packer_if.slave (config, job control, C buffer read,
//          packed output stream)
// Parameters:
//   ADDR_W      C buffer address width
//   ROWS_W      row-count width
//   FIFO_DEPTH  output FIFO depth in words (power of two, >= 2)
// Pipeline (read issued in cycle t): data on bus t+1 -> registered,
// product at t+2, SRDHM+shift at t+3, clamp/pack/push at t+4, out_valid t+5.
// ----------------------------------------------------------------------------
module tpu_requant_packer #(
   parameter int ADDR_W     = 8,
   parameter int ROWS_W     = 8,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   tpu_requant_packer_if.slave  bus
);
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W:0] DEPTH_C = (CNT_W + 1)'(FIFO_DEPTH);

   typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN} state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [ROWS_W-1:0] remaining_q, remaining_d;
   logic              done_q, done_d;
   logic [CNT_W-1:0]  inflight_q, inflight_d;
   logic [CNT_W-1:0]  fifo_count_q, fifo_count_d;
   logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
   logic [CNT_W:0]    credit_used;
   logic              rd_en;
   logic              push;
   logic              pop;
   logic [31:0]       push_word;

   // Configuration registers
   logic signed [31:0] mult_q;
   logic        [4:0]  shift_q;
   logic signed [31:0] offset_q;
   logic signed [31:0] act_min_q;
   logic signed [31:0] act_max_q;

   // Pipeline valid flags, one per stage
   logic rd_v_q, acc_v_q, prod_v_q, sh_v_q;

   // ------------------------------------------------------------------------
   // Job FSM: a read is issued only if the FIFO has room for every word that
   // is already committed (stored + in flight), so the FIFO cannot overflow.
   // ------------------------------------------------------------------------
   assign credit_used = {1'b0, fifo_count_q} + {1'b0, inflight_q};

   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      remaining_d = remaining_q;
      done_d      = 1'b0;
      rd_en       = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (bus.start) begin
               if (bus.num_rows == '0) begin
                  done_d = 1'b1;
               end else begin
                  state_d     = ST_RUN;
                  addr_d      = bus.base_addr;
                  remaining_d = bus.num_rows;
               end
            end
         end
         ST_RUN: begin
            if (credit_used < DEPTH_C) begin
               rd_en       = 1'b1;
               addr_d      = addr_q + 1'b1;
               remaining_d = remaining_q - 1'b1;
               if (remaining_q == ROWS_W'(1)) begin
                  state_d = ST_DRAIN;
               end
            end
         end
         ST_DRAIN: begin
            if (inflight_q == '0) begin
               done_d  = 1'b1;
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign pop = (fifo_count_q != '0) && bus.out_ready;

   always_comb begin
      inflight_d = inflight_q;
      if (rd_en && !push) begin
         inflight_d = inflight_q + 1'b1;
      end else if (!rd_en && push) begin
         inflight_d = inflight_q - 1'b1;
      end
   end

   always_comb begin
      fifo_count_d = fifo_count_q;
      if (push && !pop) begin
         fifo_count_d = fifo_count_q + 1'b1;
      end else if (!push && pop) begin
         fifo_count_d = fifo_count_q - 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         addr_q       <= '0;
         remaining_q  <= '0;
         done_q       <= 1'b0;
         inflight_q   <= '0;
         fifo_count_q <= '0;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         rd_v_q       <= 1'b0;
         acc_v_q      <= 1'b0;
         prod_v_q     <= 1'b0;
         sh_v_q       <= 1'b0;
         mult_q       <= 32'sh4000_0000;
         shift_q      <= 5'd0;
         offset_q     <= 32'sd0;
         act_min_q    <= -32'sd128;
         act_max_q    <= 32'sd127;
      end else begin
         state_q      <= state_d;
         addr_q       <= addr_d;
         remaining_q  <= remaining_d;
         done_q       <= done_d;
         inflight_q   <= inflight_d;
         fifo_count_q <= fifo_count_d;
         rd_v_q       <= rd_en;
         acc_v_q      <= rd_v_q;
         prod_v_q     <= acc_v_q;
         sh_v_q       <= prod_v_q;
         if (push) begin
            wr_ptr_q <= wr_ptr_q + 1'b1;
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + 1'b1;
         end
         // The pipeline only runs while busy, so config is frozen for a job.
         if (bus.cfg_we && (state_q == ST_IDLE)) begin
            case (bus.cfg_sel)
               3'd0:    mult_q    <= bus.cfg_data;
               3'd1:    shift_q   <= bus.cfg_data[4:0];
               3'd2:    offset_q  <= bus.cfg_data;
               3'd3:    act_min_q <= bus.cfg_data;
               3'd4:    act_max_q <= bus.cfg_data;
               default: ;
            endcase
         end
      end
   end

   assign push = sh_v_q;

   // ------------------------------------------------------------------------
   // Four identical requantization lanes
   // ------------------------------------------------------------------------
   for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      logic signed [31:0] acc_q;
      logic signed [63:0] prod_d, prod_q;
      logic               sat_d, sat_q;
      logic signed [63:0] nudge, nudged, biased;
      logic signed [31:0] srdhm;
      logic        [31:0] mask, rem, thr;
      logic signed [31:0] shifted;
      logic               rnd;
      logic signed [31:0] sh_d, sh_q;
      logic signed [32:0] sum33, min33, max33;

      assign prod_d = 64'(acc_q) * 64'(mult_q);
      // INT32_MIN * INT32_MIN is the only product whose high half overflows.
      assign sat_d  = (acc_q == 32'sh8000_0000) && (mult_q == 32'sh8000_0000);

      assign nudge  = prod_q[63] ? 64'shFFFF_FFFF_C000_0001 : 64'sh0000_0000_4000_0000;
      assign nudged = prod_q + nudge;
      // Arithmetic shift floors; biasing negatives by 2^31-1 makes it truncate
      // toward zero as the reference division does.
      assign biased = nudged[63] ? (nudged + 64'sh0000_0000_7FFF_FFFF) : nudged;
      assign srdhm  = sat_q ? 32'sh7FFF_FFFF : 32'(biased >>> 31);

      assign mask    = (32'd1 << shift_q) - 32'd1;
      assign rem     = $unsigned(srdhm) & mask;
      assign thr     = (mask >> 1) + {31'd0, srdhm[31]};
      assign shifted = srdhm >>> shift_q;
      assign rnd     = rem > thr;
      assign sh_d    = shifted + $signed({31'd0, rnd});

      assign sum33 = 33'(sh_q) + 33'(offset_q);
      assign min33 = 33'(act_min_q);
      assign max33 = 33'(act_max_q);
      assign push_word[8*gi +: 8] = 8'((sum33 < min33) ? min33 :
                                       (sum33 > max33) ? max33 : sum33);

      always_ff @(posedge clk) begin
         if (rd_v_q) begin
            acc_q <= $signed(bus.c_rd_data[32*gi +: 32]);
         end
         if (acc_v_q) begin
            prod_q <= prod_d;
            sat_q  <= sat_d;
         end
         if (prod_v_q) begin
            sh_q <= sh_d;
         end
      end
   end

   // ------------------------------------------------------------------------
   // Output FIFO storage; read side is combinational so out_data is valid
   // whenever out_valid is high.
   // ------------------------------------------------------------------------
   logic [31:0] fifo_mem [FIFO_DEPTH];

   always_ff @(posedge clk) begin
      if (push) begin
         fifo_mem[wr_ptr_q] <= push_word;
      end
   end

   assign bus.out_data  = fifo_mem[rd_ptr_q];
   assign bus.out_valid = (fifo_count_q != '0);
   assign bus.busy      = (state_q != ST_IDLE);
   assign bus.done      = done_q;
   assign bus.c_rd_en   = rd_en;
   assign bus.c_rd_addr = addr_q;

endmodule
